// File: rtl/onewire_rom_crc_ctrl_pkg.sv
// Shared definitions for the 1-Wire ROM ID CRC controller: FSM encodings,
// ROM geometry and the byte bit-reversal helper.
package onewire_rom_crc_ctrl_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_COLLECT = 3'd1;
    localparam logic [2:0] ST_START   = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_CHECK   = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    localparam int unsigned ROM_BYTES  = 8;
    localparam int unsigned CRC_DATA_W = 56;

    function automatic logic [7:0] bitrev8(input logic [7:0] v);
        logic [7:0] r;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/onewire_rom_crc_ctrl_rom_byte_collector.sv
// Assembles eight received bytes into the 64-bit ROM ID register; full_o marks
// the write of the final byte in the same cycle it is accepted.
module rom_byte_collector
    import onewire_rom_crc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear_i,
    input  logic        flush_i,
    input  logic        wr_i,
    input  logic [7:0]  byte_i,
    output logic [63:0] rom_id_o,
    output logic        full_o
);

    logic [2:0]  cnt_q, cnt_d;
    logic [63:0] rom_q, rom_d;

    always_comb begin
        cnt_d = cnt_q;
        rom_d = rom_q;
        if (clear_i) begin
            cnt_d = '0;
            rom_d = '0;
        end else if (flush_i) begin
            cnt_d = '0;
        end else if (wr_i) begin
            rom_d[{cnt_q, 3'b000} +: 8] = byte_i;
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
            rom_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            rom_q <= rom_d;
        end
    end

    assign full_o   = wr_i && !clear_i && !flush_i && (cnt_q == 3'(ROM_BYTES - 1));
    assign rom_id_o = rom_q;

endmodule

// File: rtl/onewire_rom_crc_ctrl.sv
// Collects a 64-bit 1-Wire ROM ID, runs the external crc8 engine over the first
// 56 wire bits and reports valid / CRC error / engine timeout.
module onewire_rom_crc_ctrl
    import onewire_rom_crc_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter bit          REFLECT     = 1'b1,
    parameter bit          REJECT_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    output logic        o_crc_start,
    output logic [55:0] o_crc_data,
    output logic        o_crc_rst,
    input  logic [7:0]  i_crc,
    input  logic        i_crc_done,
    output logic [63:0] o_rom_id,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_valid,
    output logic        o_crc_err,
    output logic        o_timeout
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC);
    // Fire when the counter is about to reach TIMEOUT_CYC-1, so o_timeout rises
    // exactly TIMEOUT_CYC cycles after the o_crc_start cycle.
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 2);

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]    crc_q, crc_d;
    logic          valid_q, valid_d, err_q, err_d, tmo_q, tmo_d;
    logic          done_q, done_d, crst_q, crst_d;
    logic          col_clear, col_flush, col_wr, col_full;
    logic [63:0]   rom_id;
    logic [7:0]    crc_exp;
    logic          match, id_zero;

    rom_byte_collector u_collector (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_i  (col_clear),
        .flush_i  (col_flush),
        .wr_i     (col_wr),
        .byte_i   (i_byte),
        .rom_id_o (rom_id),
        .full_o   (col_full)
    );

    assign col_wr  = i_byte_valid && (state_q == ST_COLLECT) && !i_abort;
    assign crc_exp = REFLECT ? bitrev8(crc_q) : crc_q;
    assign match   = (crc_exp == rom_id[63:56]);
    assign id_zero = (rom_id == '0);

    always_comb begin
        state_d   = state_q;
        to_cnt_d  = to_cnt_q;
        crc_d     = crc_q;
        valid_d   = valid_q;
        err_d     = err_q;
        tmo_d     = tmo_q;
        done_d    = 1'b0;
        crst_d    = 1'b0;
        col_clear = 1'b0;
        col_flush = 1'b0;
        if (i_abort) begin
            state_d   = ST_IDLE;
            valid_d   = 1'b0;
            err_d     = 1'b0;
            tmo_d     = 1'b0;
            col_flush = 1'b1;
            crst_d    = (state_q == ST_START) || (state_q == ST_WAIT);
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        state_d   = ST_COLLECT;
                        valid_d   = 1'b0;
                        err_d     = 1'b0;
                        tmo_d     = 1'b0;
                        col_clear = 1'b1;
                    end
                end
                ST_COLLECT: if (col_full) state_d = ST_START;
                ST_START: begin
                    to_cnt_d = '0;
                    state_d  = ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_crc_done) begin
                        crc_d   = i_crc;
                        state_d = ST_CHECK;
                    end else if (to_cnt_q == TO_LAST) begin
                        tmo_d   = 1'b1;
                        crst_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        to_cnt_d = to_cnt_q + TW'(1);
                    end
                end
                ST_CHECK: begin
                    valid_d = match && !(REJECT_ZERO && id_zero);
                    err_d   = !(match && !(REJECT_ZERO && id_zero));
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            to_cnt_q <= '0;
            crc_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
            done_q   <= 1'b0;
            crst_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            crc_q    <= crc_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
            done_q   <= done_d;
            crst_q   <= crst_d;
        end
    end

    // Whole-field reversal of bytes 0..6 puts wire bit k at [55-k].
    always_comb begin
        o_crc_data = '0;
        for (int unsigned k = 0; k < CRC_DATA_W; k++) begin
            o_crc_data[CRC_DATA_W-1-k] = rom_id[k];
        end
    end

    assign o_crc_start = (state_q == ST_START);
    assign o_crc_rst   = crst_q;
    assign o_rom_id    = rom_id;
    assign o_busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign o_done      = done_q;
    assign o_valid     = valid_q;
    assign o_crc_err   = err_q;
    assign o_timeout   = tmo_q;

endmodule
